// File: rtl/gcd_stein.sv
`default_nettype none
// ============================================================================
// Module      : gcd_stein
// Description : Binary (Stein) greatest-common-divisor engine with WIDTH-bit
//               operands, valid/ready request and result channels, and a
//               saturating count of the compute cycles spent on each job.
// Ports       : clk       - rising-edge clock
//               reset_n   - asynchronous, active-low reset
//               in_valid  - operand pair present
//               in_ready  - engine idle and able to accept a pair
//               a_in      - operand A (WIDTH bits)
//               b_in      - operand B (WIDTH bits)
//               out_valid - result present (held until out_ready)
//               out_ready - consumer takes the result
//               dout      - gcd(A, B) (WIDTH bits)
//               iters     - compute cycles for this job, saturating (CNT_W)
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_stein #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] iters
);

    // K counts common factors of two; it can reach WIDTH-1 at most.
    localparam int              K_W       = $clog2(WIDTH) + 1;
    localparam logic [K_W-1:0]   C_K_ONE   = K_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] C_ZERO    = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMON = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [K_W-1:0]   r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic [CNT_W-1:0] r_iters;

    logic             w_a_even;
    logic             w_b_even;
    logic             w_eq;
    logic             w_a_gt;
    logic             w_zero_op;
    logic [WIDTH-1:0] w_diff_ab;
    logic [WIDTH-1:0] w_diff_ba;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_a_even  = ~r_a[0];
    assign w_b_even  = ~r_b[0];
    assign w_eq      = (r_a == r_b);
    assign w_a_gt    = (r_a > r_b);
    assign w_zero_op = (a_in == C_ZERO) || (b_in == C_ZERO);
    // Only one of these is used per cycle; the rule order picks the one
    // that cannot underflow.
    assign w_diff_ab = r_a - r_b;
    assign w_diff_ba = r_b - r_a;
    // Saturating increment: the count sticks at all-ones.
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign dout      = r_dout;
    assign iters     = r_iters;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_zero_op ? S_DONE : S_COMMON;
                end
            end
            S_COMMON: begin
                if (!(w_a_even && w_b_even)) begin
                    w_state_nxt = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (w_eq) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand reduction, shift count, cycle count and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_iters <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a_in;
                        r_b   <= b_in;
                        r_k   <= '0;
                        r_cnt <= '0;
                        // gcd(x,0) = x and gcd(0,0) = 0 fall out of the OR.
                        if (w_zero_op) begin
                            r_dout  <= a_in | b_in;
                            r_iters <= '0;
                        end
                    end
                end
                S_COMMON: begin
                    r_cnt <= w_cnt_inc;
                    if (w_a_even && w_b_even) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + C_K_ONE;
                    end
                end
                S_REDUCE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_eq) begin
                        // The restored result never exceeds the larger
                        // operand, so the shift cannot lose bits.
                        r_dout  <= r_a << r_k;
                        r_iters <= w_cnt_inc;
                    end else if (w_a_even) begin
                        r_a <= r_a >> 1;
                    end else if (w_b_even) begin
                        r_b <= r_b >> 1;
                    end else if (w_a_gt) begin
                        // Difference of two odd numbers is even: halve it.
                        r_a <= w_diff_ab >> 1;
                    end else begin
                        r_b <= w_diff_ba >> 1;
                    end
                end
                default: begin
                    // DONE: result registers hold until the handshake.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
